// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC controller: FSM states,
// default address map and the exception vector.
package fetch_pc_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_TEXT_END = 32'h0000_6FFC;
  localparam logic [31:0] EXC_VECTOR       = 32'h0000_4180;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-control bus: hazard/decode requests in, fetch address and status out.
// Exception signals exist only when FETCH_PC_CTRL_EXC_EN is defined.
interface fetch_pc_ctrl_if;

  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic        state_o;
`ifdef FETCH_PC_CTRL_EXC_EN
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc_in;
  logic        fetch_adel;
`endif

  modport master (
    output stall, redirect_valid, redirect_target,
`ifdef FETCH_PC_CTRL_EXC_EN
    output exc_req, eret_req, epc_in,
    input  fetch_adel,
`endif
    input  pc, pc4, if_valid, fetch_count, state_o
  );

  modport slave (
    input  stall, redirect_valid, redirect_target,
`ifdef FETCH_PC_CTRL_EXC_EN
    input  exc_req, eret_req, epc_in,
    output fetch_adel,
`endif
    output pc, pc4, if_valid, fetch_count, state_o
  );

endinterface

// File: rtl/fetch_pc_ctrl_npc_sel.sv
// Next-PC mux, purely combinational (zero latency).
// Stall holds the current pc; exception/eret, when built in, override stall.
module npc_sel
  import fetch_pc_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  state_t      state,
  input  logic [31:0] pend_tgt,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
`ifdef FETCH_PC_CTRL_EXC_EN
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc_in,
`endif
  output logic [31:0] npc
);

  always_comb begin
    npc = pc4;
`ifdef FETCH_PC_CTRL_EXC_EN
    if (exc_req) begin
      npc = EXC_VECTOR;
    end else if (eret_req) begin
      npc = epc_in;
    end else
`endif
    if (stall) begin
      npc = pc;
    end else if (redirect_valid) begin
      // A fresh redirect at release beats the older pending target.
      npc = redirect_target;
    end else if (state == HELD) begin
      npc = pend_tgt;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register + RUN/HELD FSM; redirect reaches pc one clock after an unstalled redirect_valid.
// Stall freezes pc and defers redirects; FETCH_PC_CTRL_EXC_EN adds exc/eret loading and fetch_adel.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TEXT_END = DEFAULT_TEXT_END
) (
  input logic            clk,
  input logic            reset,
  fetch_pc_ctrl_if.slave bus
);

  if (TEXT_END < RESET_PC) begin : g_bad_map
    $error("fetch_pc_ctrl: TEXT_END below RESET_PC");
  end

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] pc_nxt;
  logic [31:0] pc4;
  logic [31:0] pend_tgt;
  logic [31:0] pend_nxt;
  logic [31:0] fetch_cnt;
  logic [31:0] tgt_eff;
  logic        exc_take;
  logic        if_valid;

`ifdef FETCH_PC_CTRL_EXC_EN
  assign tgt_eff  = bus.redirect_target;
  assign exc_take = bus.exc_req | bus.eret_req;
  assign bus.fetch_adel = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || (pc_q > TEXT_END);
`else
  // Without address-error reporting, never fetch from a misaligned target.
  assign tgt_eff  = word_align(bus.redirect_target);
  assign exc_take = 1'b0;
`endif

  assign pc4      = pc_q + 32'd4;
  assign if_valid = ~bus.stall;

  npc_sel u_npc_sel (
    .pc              (pc_q),
    .pc4             (pc4),
    .state           (state),
    .pend_tgt        (pend_tgt),
    .stall           (bus.stall),
    .redirect_valid  (bus.redirect_valid),
    .redirect_target (tgt_eff),
`ifdef FETCH_PC_CTRL_EXC_EN
    .exc_req         (bus.exc_req),
    .eret_req        (bus.eret_req),
    .epc_in          (bus.epc_in),
`endif
    .npc             (pc_nxt)
  );

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_tgt;
    if (exc_take) begin
      state_nxt = RUN;
    end else if (bus.stall) begin
      // Latest redirect seen during a stall wins.
      if (bus.redirect_valid) begin
        pend_nxt  = tgt_eff;
        state_nxt = HELD;
      end
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      state     <= RUN;
      pend_tgt  <= 32'd0;
      fetch_cnt <= 32'd0;
    end else begin
      pc_q     <= pc_nxt;
      state    <= state_nxt;
      pend_tgt <= pend_nxt;
      if (if_valid) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc4         = pc4;
  assign bus.if_valid    = if_valid;
  assign bus.fetch_count = fetch_cnt;
  assign bus.state_o     = state;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: expected pc/state queued at drive time, popped after the edge.
// Exception steps are exercised when FETCH_PC_CTRL_EXC_EN is defined.
module tb_fetch_pc_ctrl;

  localparam logic S_RUN  = 1'b0;
  localparam logic S_HELD = 1'b1;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_pc_q[$];
  logic        exp_st_q[$];

  always #5 clk = ~clk;

  fetch_pc_ctrl_if bus_if ();

  fetch_pc_ctrl #(
    .RESET_PC (32'h0000_3000),
    .TEXT_END (32'h0000_6FFC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check if_valid, then compare pc/state after the edge.
  task automatic cyc(input string tag, input logic rst, input logic st, input logic rv,
                     input logic [31:0] tgt, input logic [31:0] exp_pc, input logic exp_st);
    reset                  = rst;
    bus_if.stall           = st;
    bus_if.redirect_valid  = rv;
    bus_if.redirect_target = tgt;
    exp_pc_q.push_back(exp_pc);
    exp_st_q.push_back(exp_st);
    #1;
    chk({tag, ".if_valid"}, {31'd0, bus_if.if_valid}, {31'd0, ~st});
    @(posedge clk);
    #1;
    chk({tag, ".pc"}, bus_if.pc, exp_pc_q.pop_front());
    chk({tag, ".state"}, {31'd0, bus_if.state_o}, {31'd0, exp_st_q.pop_front()});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset                  = 1'b1;
    bus_if.stall           = 1'b0;
    bus_if.redirect_valid  = 1'b0;
    bus_if.redirect_target = 32'd0;
`ifdef FETCH_PC_CTRL_EXC_EN
    bus_if.exc_req  = 1'b0;
    bus_if.eret_req = 1'b0;
    bus_if.epc_in   = 32'd0;
`endif

    // Reset and sequential fetch
    cyc("reset", 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_3000, S_RUN);
    chk("reset.count", bus_if.fetch_count, 32'd0);
    chk("reset.pc4", bus_if.pc4, 32'h0000_3004);
    cyc("seq1", 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_3004, S_RUN);
    cyc("seq2", 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_3008, S_RUN);
    cyc("seq3", 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_300C, S_RUN);
    chk("seq.count", bus_if.fetch_count, 32'd3);
    cyc("seq4", 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_3010, S_RUN);

    // Unstalled redirect: one-clock latency
    cyc("redir", 1'b0, 1'b0, 1'b1, 32'h0000_3400, 32'h0000_3400, S_RUN);
    chk("redir.count", bus_if.fetch_count, 32'd5);

    // Back to 0x3010, then redirect during a two-clock stall
    cyc("reset2", 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_3000, S_RUN);
    for (int i = 1; i <= 4; i++) begin
      cyc("walk", 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_3000 + 32'(4 * i), S_RUN);
    end
    chk("walk.count", bus_if.fetch_count, 32'd4);
    cyc("hold1", 1'b0, 1'b1, 1'b1, 32'h0000_3400, 32'h0000_3010, S_HELD);
    chk("hold1.count", bus_if.fetch_count, 32'd4);
    cyc("hold2", 1'b0, 1'b1, 1'b1, 32'h0000_3400, 32'h0000_3010, S_HELD);
    chk("hold2.count", bus_if.fetch_count, 32'd4);
    cyc("release", 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_3400, S_RUN);
    chk("release.count", bus_if.fetch_count, 32'd5);

    // Latest pending redirect wins
    cyc("pend_a", 1'b0, 1'b1, 1'b1, 32'h0000_3400, 32'h0000_3400, S_HELD);
    cyc("pend_b", 1'b0, 1'b1, 1'b1, 32'h0000_3500, 32'h0000_3400, S_HELD);
    cyc("pend_rel", 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_3500, S_RUN);

    // Fresh redirect on release overrides the pending target
    cyc("fresh_a", 1'b0, 1'b1, 1'b1, 32'h0000_3600, 32'h0000_3500, S_HELD);
    cyc("fresh_rel", 1'b0, 1'b0, 1'b1, 32'h0000_3680, 32'h0000_3680, S_RUN);
    chk("fresh.count", bus_if.fetch_count, 32'd7);

    // Plain stall in RUN
    cyc("stall_run", 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_3680, S_RUN);
    chk("stall_run.count", bus_if.fetch_count, 32'd7);

    // Reset while HELD discards the pending target
    cyc("held_pre", 1'b0, 1'b1, 1'b1, 32'h0000_3700, 32'h0000_3680, S_HELD);
    cyc("held_rst", 1'b1, 1'b1, 1'b1, 32'h0000_3800, 32'h0000_3000, S_RUN);
    chk("held_rst.count", bus_if.fetch_count, 32'd0);
    cyc("post_rst_stall", 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_3000, S_RUN);
    cyc("post_rst_run", 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_3004, S_RUN);
    chk("post_rst.count", bus_if.fetch_count, 32'd1);

    // pc+4 wraps modulo 2^32
    cyc("wrap_a", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, S_RUN);
    chk("wrap.pc4", bus_if.pc4, 32'h0000_0000);
    cyc("wrap_b", 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0000, S_RUN);

`ifdef FETCH_PC_CTRL_EXC_EN
    chk("adel.low", {31'd0, bus_if.fetch_adel}, 32'd1);
    cyc("exc_rst", 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_3000, S_RUN);
    chk("adel.reset", {31'd0, bus_if.fetch_adel}, 32'd0);
    cyc("mis_redir", 1'b0, 1'b0, 1'b1, 32'h0000_3402, 32'h0000_3402, S_RUN);
    chk("adel.mis", {31'd0, bus_if.fetch_adel}, 32'd1);
    cyc("exc_held", 1'b0, 1'b1, 1'b1, 32'h0000_3500, 32'h0000_3402, S_HELD);
    bus_if.exc_req = 1'b1;
    cyc("exc", 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_4180, S_RUN);
    chk("adel.vec", {31'd0, bus_if.fetch_adel}, 32'd0);
    bus_if.exc_req  = 1'b0;
    bus_if.eret_req = 1'b1;
    bus_if.epc_in   = 32'h0000_3020;
    cyc("eret", 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_3020, S_RUN);
    bus_if.eret_req = 1'b0;
    cyc("after_eret", 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_3024, S_RUN);
`else
    cyc("align_rst", 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_3000, S_RUN);
    cyc("align_redir", 1'b0, 1'b0, 1'b1, 32'h0000_3402, 32'h0000_3400, S_RUN);
    cyc("align_held", 1'b0, 1'b1, 1'b1, 32'h0000_3503, 32'h0000_3400, S_HELD);
    cyc("align_rel", 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_3500, S_RUN);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
